// File: rtl/apb_slave_mem_pkg.sv
// Shared APB definitions for the slave-side completers: bus widths,
// completer state encoding and the reset value of the read-data register.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  localparam logic [APB_DATA_W-1:0] PRDATA_RST = 8'h00;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_slv_state_t;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB completer bus bundle.
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : requester -> completer
//   PRDATA, PREADY, PSLVERR              : completer -> requester
// The master modport belongs to the bridge side, the slave modport to the
// completer.
interface apb_slave_mem_if;
  import apb_pkg::*;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_ram.sv
// Single-port DEPTH x 8 storage for the APB completer.
//   clk, rst_n        : clock, synchronous active-low reset (read register only)
//   we, wr_addr, wdata: write port; out-of-range addresses are discarded
//   rd_en, rd_addr    : read request; the result lands in rdata next cycle
//   rdata             : registered read data, 8'h00 for out-of-range reads,
//                       holds its value while rd_en is low
// Memory contents are never cleared by reset.
module apb_slave_ram
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [APB_ADDR_W-1:0] wr_addr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic                  rd_en,
  input  logic [APB_ADDR_W-1:0] rd_addr,
  output logic [APB_DATA_W-1:0] rdata
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [APB_DATA_W-1:0] mem [DEPTH];
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = (32'(wr_addr) < DEPTH);
  assign rd_ok = (32'(rd_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (we && wr_ok) begin
      mem[wr_addr[IW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= PRDATA_RST;
    end else if (rd_en) begin
      rdata <= rd_ok ? mem[rd_addr[IW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with byte-wide storage and programmable wait states.
//   PCLK     : clock, all state updates on the rising edge
//   PRESETn  : synchronous active-low reset (memory contents retained)
//   apb      : APB slave bundle (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//              PRDATA/PREADY/PSLVERR out)
// Parameters: DEPTH (1..256 byte locations), WAIT_STATES (0..7).
// Build option APB_SLAVE_PSLVERR_EN: drive PSLVERR for out-of-range accesses
// and for transfers that skipped the setup cycle; otherwise PSLVERR is 0.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_slave_mem_if.slave   apb
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  apb_slv_state_t        state, state_n;
  logic [2:0]            cnt, cnt_n;
  logic [APB_ADDR_W-1:0] addr_q, addr_n;
  logic                  write_q, write_n;
  logic                  viol_q, viol_n;
  logic                  ready;
  logic                  mem_we;
  logic                  rd_en;
  logic [APB_DATA_W-1:0] rd_data;

  assign ready = (state == ACCESS) && (cnt == '0);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      viol_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr_q  <= addr_n;
      write_q <= write_n;
      viol_q  <= viol_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    write_n = write_q;
    viol_n  = viol_q;
    mem_we  = 1'b0;
    rd_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (apb.PSEL) begin
          state_n = ACCESS;
          addr_n  = apb.PADDR;
          write_n = apb.PWRITE;
          if (!apb.PENABLE) begin
            cnt_n  = WAIT_INIT;
            viol_n = 1'b0;
            rd_en  = !apb.PWRITE;
          end else begin
            // No setup cycle: complete immediately, never touch memory.
            cnt_n  = '0;
            viol_n = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_n = IDLE;
          cnt_n   = '0;
          viol_n  = 1'b0;
        end else if (apb.PENABLE) begin
          if (cnt != '0) begin
            cnt_n = cnt - 3'd1;
          end else begin
            mem_we  = write_q && !viol_q;
            state_n = IDLE;
            viol_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  apb_slave_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .we      (mem_we),
    .wr_addr (addr_q),
    .wdata   (apb.PWDATA),
    .rd_en   (rd_en),
    .rd_addr (apb.PADDR),
    .rdata   (rd_data)
  );

  assign apb.PRDATA = rd_data;
  assign apb.PREADY = ready;

`ifdef APB_SLAVE_PSLVERR_EN
  assign apb.PSLVERR = ready && ((32'(addr_q) >= DEPTH) || viol_q);
`else
  assign apb.PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;

`ifdef APB_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] rd;
    logic       err;
    int         waits;
    bit         is_rd;
  } exp_t;

  logic       PCLK = 1'b0;
  logic       presetn;
  logic       psel_a, psel_b, penable, pwrite;
  logic [7:0] paddr, pwdata;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  always #5 PCLK = ~PCLK;

  apb_slave_mem_if if_a ();
  apb_slave_mem_if if_b ();

  assign if_a.PSEL    = psel_a;
  assign if_a.PENABLE = penable;
  assign if_a.PWRITE  = pwrite;
  assign if_a.PADDR   = paddr;
  assign if_a.PWDATA  = pwdata;
  assign if_b.PSEL    = psel_b;
  assign if_b.PENABLE = penable;
  assign if_b.PWRITE  = pwrite;
  assign if_b.PADDR   = paddr;
  assign if_b.PWDATA  = pwdata;

  apb_slave_mem #(.DEPTH(64), .WAIT_STATES(0)) u_a (
    .PCLK(PCLK), .PRESETn(presetn), .apb(if_a)
  );
  apb_slave_mem #(.DEPTH(64), .WAIT_STATES(3)) u_b (
    .PCLK(PCLK), .PRESETn(presetn), .apb(if_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit which, output logic [7:0] rd, output logic rdy, output logic err);
    if (which) begin
      rd = if_b.PRDATA; rdy = if_b.PREADY; err = if_b.PSLVERR;
    end else begin
      rd = if_a.PRDATA; rdy = if_a.PREADY; err = if_a.PSLVERR;
    end
  endtask

  task automatic cycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_bus();
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  // Full transfer; changes PADDR/PWRITE during the access phase to confirm
  // the completer works from its latched copies.
  task automatic xfer(input bit which, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input bit exp_err, input int exp_wait);
    exp_t e;
    logic [7:0] rd;
    logic rdy, err;
    int waits;
    bit done;
    e.rd = exp_rd; e.err = exp_err; e.waits = exp_wait; e.is_rd = !wr;
    sb.push_back(e);
    psel_a = !which; psel_b = which; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d;
    cycle();
    penable = 1'b1;
    paddr   = ~a;
    pwrite  = !wr;
    waits = 0; done = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      sample(which, rd, rdy, err);
      if (!wr) chk("rd_stable", rd, exp_rd);
      if (rdy) done = 1'b1;
      else begin
        waits++;
        cycle();
      end
    end
    if (!done) chk("ready_timeout", {7'b0, rdy}, 8'h01);
    e = sb.pop_front();
    chk("wait_count", 8'(waits), 8'(e.waits));
    chk("pslverr", {7'b0, err}, {7'b0, e.err});
    if (e.is_rd) chk("prdata", rd, e.rd);
    cycle();
    idle_bus();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic rdy, err;

    presetn = 1'b0;
    idle_bus();
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) cycle();
    sample(0, rd, rdy, err);
    chk("rst_a_pready", {7'b0, rdy}, 8'h00);
    chk("rst_a_prdata", rd, 8'h00);
    chk("rst_a_pslverr", {7'b0, err}, 8'h00);
    sample(1, rd, rdy, err);
    chk("rst_b_pready", {7'b0, rdy}, 8'h00);
    chk("rst_b_prdata", rd, 8'h00);
    chk("rst_b_pslverr", {7'b0, err}, 8'h00);
    presetn = 1'b1;
    cycle();

    // Zero-wait write/read, back to back.
    xfer(0, 1, 8'h10, 8'hA5, 8'h00, 0, 0);
    xfer(0, 0, 8'h10, 8'h00, 8'hA5, 0, 0);

    // Three wait states.
    xfer(1, 1, 8'h05, 8'h5A, 8'h00, 0, 3);
    xfer(1, 0, 8'h05, 8'h00, 8'h5A, 0, 3);

    // Range boundary and out-of-range handling.
    xfer(0, 1, 8'h00, 8'h12, 8'h00, 0, 0);
    xfer(0, 1, 8'h3F, 8'hC3, 8'h00, 0, 0);
    xfer(0, 1, 8'h40, 8'h3C, 8'h00, ERR_EN, 0);
    xfer(0, 0, 8'h40, 8'h00, 8'h00, ERR_EN, 0);
    xfer(0, 0, 8'h3F, 8'h00, 8'hC3, 0, 0);
    xfer(0, 0, 8'h00, 8'h00, 8'h12, 0, 0);

    // Abort a write after one wait cycle.
    xfer(1, 1, 8'h20, 8'h77, 8'h00, 0, 3);
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h99;
    cycle();
    penable = 1'b1;
    cycle();
    idle_bus();
    cycle();
    sample(1, rd, rdy, err);
    chk("abort_idle_pready", {7'b0, rdy}, 8'h00);
    chk("abort_prdata_held", rd, 8'h5A);
    xfer(1, 0, 8'h20, 8'h00, 8'h77, 0, 3);

    // Reset during the wait phase of a read.
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
    cycle();
    penable = 1'b1;
    cycle();
    presetn = 1'b0;
    cycle();
    sample(1, rd, rdy, err);
    chk("midrst_pready", {7'b0, rdy}, 8'h00);
    chk("midrst_prdata", rd, 8'h00);
    chk("midrst_pslverr", {7'b0, err}, 8'h00);
    presetn = 1'b1;
    idle_bus();
    cycle();
    xfer(1, 0, 8'h05, 8'h00, 8'h5A, 0, 3);
    xfer(0, 0, 8'h10, 8'h00, 8'hA5, 0, 0);

    // Access phase without a setup cycle.
    xfer(0, 1, 8'h11, 8'h33, 8'h00, 0, 0);
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h11; pwdata = 8'hEE;
    cycle();
    sample(0, rd, rdy, err);
    chk("viol_pready", {7'b0, rdy}, 8'h01);
    chk("viol_pslverr", {7'b0, err}, {7'b0, ERR_EN});
    cycle();
    idle_bus();
    xfer(0, 0, 8'h11, 8'h00, 8'h33, 0, 0);

    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
